// File: rtl/step_sequencer.sv
// Drum-pattern step sequencer.
// Plays a VOICES x STEPS pattern, one column per rising edge of the tempo
// square wave, and drives a trigger pulse and a fixed-length gate for each
// voice hit at that column.

// Per-voice gate generator: a down-counter reloaded by each trigger.
module step_gate #(
  parameter int GATE_CYC = 8,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  output logic gate
);

  logic [CW-1:0] cnt;

  // Reload on a hit, otherwise count down. The gate is registered from the
  // counter's next value, so it rises together with the trigger pulse.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      gate <= 1'b0;
    end else if (load) begin
      cnt  <= CW'(GATE_CYC);
      gate <= 1'b1;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      gate <= (cnt > CW'(1));
    end
  end

endmodule

module step_sequencer #(
  parameter int VOICES   = 4,
  parameter int STEPS    = 16,
  parameter int GATE_CYC = 8,
  localparam int SW      = $clog2(STEPS),
  localparam int VW      = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              run,
  input  logic [SW-1:0]     len,
  input  logic              wr_en,
  input  logic [VW-1:0]     wr_voice,
  input  logic [SW-1:0]     wr_step,
  input  logic              wr_val,
  output logic [SW-1:0]     step,
  output logic              playing,
  output logic [VOICES-1:0] trig,
  output logic [VOICES-1:0] gate,
  output logic              beat
);

  localparam int CW = $clog2(GATE_CYC + 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                         state, state_nxt;
  logic                           clr;
  logic [2:0]                     sync_q;
  logic                           adv;
  logic                           fire;
  logic [VOICES-1:0][STEPS-1:0]   pat;
  logic [VOICES-1:0]              col;

  // Two flops of synchronizer plus one of history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], tick};
  end

  // Registered rising-edge detect of the synchronized tempo; falls are ignored.
  always_ff @(posedge clk) begin
    if (rst) adv <= 1'b0;
    else     adv <= sync_q[1] & ~sync_q[2];
  end

  // Pattern RAM; a write coincident with playback of the same cell lands
  // after the read, so the old value plays this pass.
  always_ff @(posedge clk) begin
    if (rst)        pat <= '0;
    else if (wr_en) pat[wr_voice][wr_step] <= wr_val;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; leaving PLAY rewinds the step and kills the gates.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      IDLE: if (run) state_nxt = PLAY;
      PLAY: if (!run) begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An advance landing in the same cycle as the stop request is dropped.
  assign fire    = (state == PLAY) && adv && run;
  assign playing = (state == PLAY);

  // Column of the pattern at the current step pointer.
  always_comb begin
    col = '0;
    for (int v = 0; v < VOICES; v++) col[v] = pat[v][step];
  end

  // Step pointer, trigger pulses and bar marker. Wrap uses >= so that a
  // shrinking loop length never strands the pointer past the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= '0;
      trig <= '0;
      beat <= 1'b0;
    end else begin
      trig <= '0;
      beat <= 1'b0;
      if (clr || state == IDLE) begin
        step <= '0;
      end else if (fire) begin
        trig <= col;
        beat <= (step == '0);
        step <= (step >= len) ? '0 : step + SW'(1);
      end
    end
  end

  // One gate generator per voice, loaded on the same edge as its trigger.
  for (genvar v = 0; v < VOICES; v++) begin : g_gate
    step_gate #(
      .GATE_CYC (GATE_CYC),
      .CW       (CW)
    ) u_gate (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .load (fire & col[v]),
      .gate (gate[v])
    );
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: reference model of the pattern player, a fixed
// vector table for the short-loop case, hand sequences for the corner cases
// and a randomized section checked against the model.
module tb_step_sequencer;

  localparam int V = 4;
  localparam int S = 16;
  localparam int G = 8;

  logic         clk = 1'b0;
  logic         rst, tick, run, wr_en, wr_val;
  logic [3:0]   len, wr_step, step;
  logic [1:0]   wr_voice;
  logic         playing, beat;
  logic [V-1:0] trig, gate;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  bit mpat [V][S];
  int mstep, mlen;
  bit mplay;

  typedef struct {
    logic [3:0] s;
    logic       b;
    logic [3:0] t;
  } vec_t;
  vec_t tbl [10];

  step_sequencer #(.VOICES(V), .STEPS(S), .GATE_CYC(G)) dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .len(len),
    .wr_en(wr_en), .wr_voice(wr_voice), .wr_step(wr_step), .wr_val(wr_val),
    .step(step), .playing(playing), .trig(trig), .gate(gate), .beat(beat)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] mcol(input int s);
    logic [3:0] r;
    for (int v = 0; v < V; v++) r[v] = mpat[v][s];
    return r;
  endfunction

  task automatic wr(input int v, input int s, input bit val);
    wr_en = 1'b1; wr_voice = 2'(v); wr_step = 4'(s); wr_val = val;
    cyc(1);
    wr_en = 1'b0;
    mpat[v][s] = val;
  endtask

  task automatic model_clear();
    for (int v = 0; v < V; v++)
      for (int s = 0; s < S; s++) mpat[v][s] = 1'b0;
    mstep = 0;
  endtask

  // One tempo pulse; samples on the trigger cycle (4 clk after the rise).
  // Optionally places a write in the cycle where the advance is being taken.
  task automatic tick_chk(input string nm, input int extra,
                          input bit cw, input int cv, input int cs, input bit cval,
                          output logic [3:0] st, output logic sb, output logic [3:0] ss);
    logic [3:0] et;
    logic       eb;
    et = '0; eb = 1'b0;
    if (mplay) begin
      et = mcol(mstep);
      eb = (mstep == 0);
      mstep = (mstep >= mlen) ? 0 : mstep + 1;
    end
    tick = 1'b1; cyc(2);
    tick = 1'b0; cyc(1);
    if (cw) begin
      wr_en = 1'b1; wr_voice = 2'(cv); wr_step = 4'(cs); wr_val = cval;
    end
    cyc(1);
    wr_en = 1'b0;
    if (cw) mpat[cv][cs] = cval;
    st = trig; sb = beat; ss = step;
    chk({nm, " trig"}, trig, et);
    chk({nm, " beat"}, beat, eb);
    chk({nm, " step"}, step, mstep);
    chk({nm, " gate"}, gate & et, et);
    cyc(1);
    chk({nm, " trig width"}, trig, 0);
    cyc(extra);
  endtask

  task automatic tk(input string nm, input int extra);
    logic [3:0] a, c;
    logic b;
    tick_chk(nm, extra, 1'b0, 0, 0, 1'b0, a, b, c);
  endtask

  initial begin
    logic [3:0] t_o, s_o;
    logic       b_o;
    int         n, lows;

    tbl = '{
      '{4'd1, 1'b1, 4'b0010}, '{4'd2, 1'b0, 4'b0010}, '{4'd3, 1'b0, 4'b0010},
      '{4'd0, 1'b0, 4'b0010}, '{4'd1, 1'b1, 4'b0010}, '{4'd2, 1'b0, 4'b0010},
      '{4'd3, 1'b0, 4'b0010}, '{4'd0, 1'b0, 4'b0010}, '{4'd1, 1'b1, 4'b0010},
      '{4'd2, 1'b0, 4'b0010}
    };

    rst = 1'b1; tick = 1'b0; run = 1'b0; len = 4'd15;
    wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_val = 1'b0;
    model_clear(); mplay = 1'b0; mlen = 15;
    cyc(2);
    rst = 1'b0;
    chk("reset trig", trig, 0);
    chk("reset gate", gate, 0);
    chk("reset beat", beat, 0);
    chk("reset step", step, 0);
    chk("reset playing", playing, 0);

    // four-on-the-floor on voice 0, full 16-step loop
    wr(0, 0, 1); wr(0, 4, 1); wr(0, 8, 1); wr(0, 12, 1);
    run = 1'b1; cyc(1); mplay = 1'b1;
    chk("start playing", playing, 1);
    for (int i = 0; i < 16; i++) begin
      tick_chk("loop16", 2, 1'b0, 0, 0, 1'b0, t_o, b_o, s_o);
      chk("loop16 voice0 hit", t_o[0], (i % 4 == 0));
      chk("loop16 bar", b_o, (i == 0));
    end
    chk("loop16 rewound", step, 0);

    // shrink the loop below the current step
    for (int i = 0; i < 10; i++) tk("pre-shrink", 1);
    chk("at step 10", step, 10);
    len = 4'd5; mlen = 5;
    tick_chk("shrink", 1, 1'b0, 0, 0, 1'b0, t_o, b_o, s_o);
    chk("shrink wraps", s_o, 0);

    // gate length: one-step loop whose step 0 hits voice 0
    len = 4'd0; mlen = 0;
    tk("gate single", 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (gate[0]) n++;
      cyc(1);
    end
    chk("gate length", n + 1, G);

    // retrigger every 5 clk: gate must never drop
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      tick = ((i % 5) < 2);
      cyc(1);
      if (i >= 4 && !gate[0]) lows++;
    end
    tick = 1'b0;
    chk("retrigger gate gaps", lows, 0);
    cyc(12);
    chk("gate drained", gate, 0);

    // short loop from the vector table
    rst = 1'b1; cyc(1); rst = 1'b0;
    model_clear(); mplay = 1'b0;
    cyc(1); mplay = 1'b1;
    for (int s = 0; s < S; s++) wr(1, s, 1);
    len = 4'd3; mlen = 3;
    for (int i = 0; i < 10; i++) begin
      tick_chk("table", 1, 1'b0, 0, 0, 1'b0, t_o, b_o, s_o);
      chk("tbl step", s_o, tbl[i].s);
      chk("tbl beat", b_o, tbl[i].b);
      chk("tbl trig", t_o, tbl[i].t);
    end

    // write coincident with playback of the same cell
    while (mstep != 0) tk("align", 1);
    tick_chk("coincident wr", 1, 1'b1, 2, 0, 1'b1, t_o, b_o, s_o);
    chk("coincident old value", t_o[2], 0);
    for (int i = 0; i < 3; i++) tk("next loop", 1);
    tick_chk("new value", 1, 1'b0, 0, 0, 1'b0, t_o, b_o, s_o);
    chk("new value plays", t_o[2], 1);

    // random pattern edits, loop lengths and tick spacing
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) wr($urandom_range(0, V - 1), $urandom_range(0, S - 1), 1'($urandom_range(0, 1)));
      else if (r == 3) begin
        len = 4'($urandom_range(0, S - 1)); mlen = len;
      end else tk("random", $urandom_range(0, 3));
    end

    // stop while a gate is high
    wr(3, mstep, 1);
    tk("pre-stop", 0);
    run = 1'b0; cyc(1);
    mplay = 1'b0; mstep = 0;
    chk("stop playing", playing, 0);
    chk("stop step", step, 0);
    chk("stop gate", gate, 0);
    tk("idle tick", 1);
    tk("idle tick", 1);

    // reset during play clears the pattern
    run = 1'b1; cyc(1); mplay = 1'b1;
    tk("pre-reset", 0);
    rst = 1'b1; cyc(1);
    chk("rst trig", trig, 0);
    chk("rst gate", gate, 0);
    chk("rst beat", beat, 0);
    chk("rst step", step, 0);
    chk("rst playing", playing, 0);
    rst = 1'b0;
    model_clear(); mplay = 1'b0;
    cyc(1); mplay = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_chk("post-reset", 1, 1'b0, 0, 0, 1'b0, t_o, b_o, s_o);
      chk("post-reset empty", t_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
